// File: rtl/tlb_sv39_flex.sv
// rtl/tlb_sv39_flex.sv - parametrised fully-associative Sv39 TLB
// Combinational lookup, selective SFENCE.VMA flush, single PTW refill FSM.
module tlb_sv39_flex #(
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned VPN_WIDTH  = 27,
  parameter int unsigned PPN_WIDTH  = 44,
  parameter int unsigned ASID_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [VPN_WIDTH-1:0]  req_vpn_i,
  input  logic [ASID_WIDTH-1:0] req_asid_i,
  input  logic                  req_store_i,
  input  logic                  req_fetch_i,
  input  logic                  vm_enable_i,
  input  logic [1:0]            priv_lvl_i,
  input  logic                  sum_i,
  input  logic                  mxr_i,
  output logic                  resp_hit_o,
  output logic                  resp_miss_o,
  output logic [PPN_WIDTH-1:0]  resp_ppn_o,
  output logic                  resp_xcpt_o,
  output logic                  ptw_req_valid_o,
  input  logic                  ptw_req_ready_i,
  output logic [VPN_WIDTH-1:0]  ptw_req_vpn_o,
  output logic [ASID_WIDTH-1:0] ptw_req_asid_o,
  output logic                  ptw_req_store_o,
  output logic                  ptw_req_fetch_o,
  input  logic                  ptw_resp_valid_i,
  input  logic                  ptw_resp_error_i,
  input  logic [1:0]            ptw_resp_level_i,
  input  logic [PPN_WIDTH-1:0]  ptw_resp_ppn_i,
  input  logic [7:0]            ptw_resp_perm_i,
  input  logic                  flush_valid_i,
  output logic                  flush_ready_o,
  input  logic                  flush_asid_en_i,
  input  logic [ASID_WIDTH-1:0] flush_asid_i,
  input  logic                  flush_vpn_en_i,
  input  logic [VPN_WIDTH-1:0]  flush_vpn_i,
  output logic                  pmu_access_o,
  output logic                  pmu_miss_o
);
  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  typedef struct packed {
    logic [VPN_WIDTH-1:0]  vpn;
    logic [ASID_WIDTH-1:0] asid;
    logic [PPN_WIDTH-1:0]  ppn;
    logic [1:0]            level;
    logic                  u, g, r, w, x, a, d;
  } entry_t;

  entry_t                tag_q [ENTRIES];
  logic [ENTRIES-1:0]    valid_q, valid_d, valid_lk, lk_match, fl_match;
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rr_q, rr_d, victim_q, victim_d, victim, hit_idx;
  logic [VPN_WIDTH-1:0]  miss_vpn_q, miss_vpn_d;
  logic [ASID_WIDTH-1:0] miss_asid_q, miss_asid_d;
  logic                  miss_store_q, miss_store_d, miss_fetch_q, miss_fetch_d;
  logic                  hit_any, priv_ok, acc_ok, perm_ok, need_ad, ad_inval;
  logic                  accept, do_miss, refill_we;
  logic [PPN_WIDTH-1:0]  hit_ppn;
  entry_t                refill_e;
  logic                  unused_perm_v;

  // Bits of the VPN that take part in a compare for a leaf at the given level.
  function automatic logic [VPN_WIDTH-1:0] level_mask(input logic [1:0] level);
    logic [VPN_WIDTH-1:0] m;
    m = '1;
    if (level == 2'd2)      m[17:0] = '0;
    else if (level == 2'd1) m[8:0]  = '0;
    return m;
  endfunction

  assign req_ready_o     = (state_q == IDLE) && !flush_valid_i;
  assign flush_ready_o   = 1'b1;
  assign accept          = req_valid_i && req_ready_o;
  assign pmu_access_o    = accept;
  assign pmu_miss_o      = do_miss;
  assign ptw_req_valid_o = (state_q == REQ);
  assign ptw_req_vpn_o   = miss_vpn_q;
  assign ptw_req_asid_o  = miss_asid_q;
  assign ptw_req_store_o = miss_store_q;
  assign ptw_req_fetch_o = miss_fetch_q;
  assign unused_perm_v   = ptw_resp_perm_i[0];

  always_comb begin
    lk_match = '0;
    fl_match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_match[i] = valid_q[i] && (tag_q[i].g || (tag_q[i].asid == req_asid_i))
                    && (((tag_q[i].vpn ^ req_vpn_i) & level_mask(tag_q[i].level)) == '0);
      fl_match[i] = valid_q[i]
                    && (!flush_asid_en_i || ((tag_q[i].asid == flush_asid_i) && !tag_q[i].g))
                    && (!flush_vpn_en_i
                        || (((tag_q[i].vpn ^ flush_vpn_i) & level_mask(tag_q[i].level)) == '0));
    end
  end

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lk_match[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    // S-mode may touch user data only with SUM, and never execute from it.
    priv_ok = (priv_lvl_i == 2'd0) ? tag_q[hit_idx].u
                                   : (!tag_q[hit_idx].u || (sum_i && !req_fetch_i));
    acc_ok  = req_fetch_i ? tag_q[hit_idx].x :
              req_store_i ? tag_q[hit_idx].w :
                            (tag_q[hit_idx].r || (mxr_i && tag_q[hit_idx].x));
    perm_ok = priv_ok && acc_ok;
    need_ad = hit_any && perm_ok && (!tag_q[hit_idx].a || (req_store_i && !tag_q[hit_idx].d));
    hit_ppn = tag_q[hit_idx].ppn;
    if (tag_q[hit_idx].level == 2'd2)      hit_ppn[17:0] = req_vpn_i[17:0];
    else if (tag_q[hit_idx].level == 2'd1) hit_ppn[8:0]  = req_vpn_i[8:0];

    resp_hit_o  = 1'b0;
    resp_miss_o = 1'b0;
    resp_xcpt_o = 1'b0;
    resp_ppn_o  = '0;
    do_miss     = 1'b0;
    ad_inval    = 1'b0;
    if (accept) begin
      if (!vm_enable_i) begin
        resp_hit_o = 1'b1;
        resp_ppn_o = PPN_WIDTH'(req_vpn_i);
      end else if (hit_any && !need_ad) begin
        resp_hit_o  = 1'b1;
        resp_xcpt_o = !perm_ok;
        resp_ppn_o  = hit_ppn;
      end else begin
        resp_miss_o = 1'b1;
        do_miss     = 1'b1;
        ad_inval    = need_ad;
      end
    end

    valid_lk = valid_q;
    if (ad_inval) valid_lk[hit_idx] = 1'b0;
    victim = rr_q;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_lk[i]) victim = IDX_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    victim_d     = victim_q;
    miss_vpn_d   = miss_vpn_q;
    miss_asid_d  = miss_asid_q;
    miss_store_d = miss_store_q;
    miss_fetch_d = miss_fetch_q;
    refill_we    = 1'b0;
    valid_d      = valid_lk;
    case (state_q)
      IDLE: if (do_miss) begin
        state_d      = REQ;
        victim_d     = victim;
        miss_vpn_d   = req_vpn_i;
        miss_asid_d  = req_asid_i;
        miss_store_d = req_store_i;
        miss_fetch_d = req_fetch_i;
      end
      REQ: begin
        if (flush_valid_i)        state_d = ptw_req_ready_i ? DROP : IDLE;
        else if (ptw_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        // A response landing with the flush is consumed but discarded.
        if (flush_valid_i) state_d = ptw_resp_valid_i ? IDLE : DROP;
        else if (ptw_resp_valid_i) begin
          state_d   = IDLE;
          refill_we = 1'b1;
          rr_d      = rr_q + IDX_W'(1);
        end
      end
      DROP: if (ptw_resp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (refill_we) valid_d[victim_q] = !ptw_resp_error_i;
    if (flush_valid_i) valid_d = valid_d & ~fl_match;
  end

  always_comb begin
    refill_e.vpn   = miss_vpn_q;
    refill_e.asid  = miss_asid_q;
    refill_e.ppn   = ptw_resp_ppn_i;
    refill_e.level = ptw_resp_level_i;
    {refill_e.d, refill_e.a, refill_e.g, refill_e.u,
     refill_e.x, refill_e.w, refill_e.r} = ptw_resp_perm_i[7:1];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      victim_q     <= '0;
      valid_q      <= '0;
      miss_vpn_q   <= '0;
      miss_asid_q  <= '0;
      miss_store_q <= 1'b0;
      miss_fetch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      victim_q     <= victim_d;
      valid_q      <= valid_d;
      miss_vpn_q   <= miss_vpn_d;
      miss_asid_q  <= miss_asid_d;
      miss_store_q <= miss_store_d;
      miss_fetch_q <= miss_fetch_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (refill_we) tag_q[victim_q] <= refill_e;
  end
endmodule

// File: doc/tlb_sv39_flex.md
Name: tlb_sv39_flex

Overview:
- Parametrised, fully-associative Sv39 TLB; successor to the current fixed 8-entry TLB.
- Sits between a translation requester (icache/dcache/LSU) and the shared PTW.
- Adds over the current block: configurable depth and widths, global-page support, selective SFENCE.VMA flush (by ASID and/or VPN), round-robin/first-free replacement, and A/D-bit refetch on a single refill FSM.

Parameters:
- ENTRIES, 16, number of TLB entries (power of 2, 2..64).
- VPN_WIDTH, 27, virtual page number width (3 levels x 9 bits).
- PPN_WIDTH, 44, physical page number width.
- ASID_WIDTH, 16, address-space identifier width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  translation request valid
- req_ready_o  out  1  TLB accepts lookups (FSM in IDLE, no flush active)
- req_vpn_i  in  VPN_WIDTH  request VPN
- req_asid_i  in  ASID_WIDTH  request ASID
- req_store_i  in  1  request is a store
- req_fetch_i  in  1  request is an instruction fetch
- vm_enable_i  in  1  translation enabled
- priv_lvl_i  in  2  0 = user, otherwise supervisor
- sum_i  in  1  mstatus.SUM
- mxr_i  in  1  mstatus.MXR
- resp_hit_o  out  1  valid translation this cycle
- resp_miss_o  out  1  lookup missed (refill started)
- resp_ppn_o  out  PPN_WIDTH  translated PPN (superpage low bits taken from the VPN); equals zero-extended VPN when vm_enable_i=0
- resp_xcpt_o  out  1  page fault for the access type
- ptw_req_valid_o  out  1  refill request
- ptw_req_ready_i  in  1  PTW accepts request
- ptw_req_vpn_o  out  VPN_WIDTH  stored miss VPN
- ptw_req_asid_o  out  ASID_WIDTH  stored miss ASID
- ptw_req_store_o  out  1  stored store flag
- ptw_req_fetch_o  out  1  stored fetch flag
- ptw_resp_valid_i  in  1  PTW response
- ptw_resp_error_i  in  1  PTW fault
- ptw_resp_level_i  in  2  0 = 4K, 1 = 2M, 2 = 1G
- ptw_resp_ppn_i  in  PPN_WIDTH  leaf PPN
- ptw_resp_perm_i  in  8  PTE bits {d,a,g,u,x,w,r,v}
- flush_valid_i  in  1  SFENCE.VMA request
- flush_ready_o  out  1  flush accepted this cycle
- flush_asid_en_i  in  1  restrict flush to flush_asid_i
- flush_asid_i  in  ASID_WIDTH  ASID to flush
- flush_vpn_en_i  in  1  restrict flush to flush_vpn_i
- flush_vpn_i  in  VPN_WIDTH  VPN to flush
- pmu_access_o  out  1  accepted-lookup pulse
- pmu_miss_o  out  1  accepted-miss pulse

Behaviour:
- **Reset:** all entries invalid, FSM = IDLE, round-robin pointer = 0, miss register = 0. All outputs 0 except req_ready_o = 1 and flush_ready_o = 1.
- **Entry fields:** vpn, asid, ppn, level, u, g, r, w, x, a, d, valid.
- **Lookup (0-cycle latency, combinational):**
  - Entry matches when valid, ASID equal or g=1, and the VPN compared on bits [26:18] for level 2, [26:9] for level 1, full VPN for level 0.
  - At most one entry matches; on multiple matches the lowest index wins.
- **Hit (vm_enable_i=1, request accepted):**
  - Permissions:
    - Supervisor needs !u, or u with sum_i (data accesses only; a fetch from a u page in S-mode always faults).
    - User needs u.
    - Read allowed by r, or by x when mxr_i=1.
    - Write needs w. Fetch needs x.
  - Permission violation: resp_hit_o = 1, resp_xcpt_o = 1.
  - If permitted but a=0, or store with d=0: the entry is invalidated in the same cycle and the lookup is treated as a miss (PTW sets A/D).
- **Miss:**
  - resp_miss_o = 1 and pmu_miss_o = 1 in the acceptance cycle.
  - Capture the request into the miss register plus a victim index.
  - Victim is the lowest-index invalid entry, else the round-robin pointer (pointer increments after each refill, wrapping ENTRIES-1 -> 0).
- **vm_enable_i=0:** resp_hit_o = 1, no exception, no PMU miss, no FSM change.
- **FSM:**
  - IDLE: miss -> REQ.
  - REQ: ptw_req_valid_o = 1, outputs held from the miss register; ptw_req_ready_i -> WAIT.
  - WAIT: ptw_resp_valid_i -> write victim entry, valid = !ptw_resp_error_i, -> IDLE.
  - A flush in REQ with !ptw_req_ready_i -> IDLE, request dropped.
  - A flush in REQ with ready, or in WAIT -> DROP.
  - DROP: ptw_resp_valid_i -> IDLE without writing.
  - req_ready_o = 1 only in IDLE with no flush_valid_i.
- **Flush (single cycle, always accepted, flush_ready_o = 1):** invalidates every entry where
  - (!flush_asid_en_i or (asid == flush_asid_i and g=0)), and
  - (!flush_vpn_en_i or VPN matches at the entry's level).
  - Flush has priority over a same-cycle refill write: the refill is discarded if the FSM is in WAIT.
  - A lookup is blocked in the flush cycle.
- Asynchronous reset mid-refill returns to IDLE; a late PTW response is ignored.

Test Plan:
- **Cold miss/refill:** VPN 0x0001234, ASID 5, load → resp_miss_o = 1, ptw_req_vpn_o = 0x0001234 one cycle later. PTW replies level 0, PPN 0xABCDE, perm 0x4F (a,x,w,r,v, u=0) → entry 0 written; identical S-mode repeat lookup gives resp_hit_o = 1, resp_ppn_o = 0xABCDE, xcpt = 0.
- **Megapage:** refill at level 1 with PPN 0x200 × 512; lookup VPN 0x0000 1FF in the same 2M region → resp_ppn_o low 9 bits = 0x1FF.
- **Store to clean page:** 4K entry with d=0 (perm 0x4F), store → entry invalidated, resp_miss_o = 1. PTW returns perm 0xCF → next store hits, no xcpt.
- **ASID-selective flush:** entries ASID 3 (g=0), ASID 3 (g=1), ASID 4; flush asid_en = 1, ASID 3 → only the first entry invalidated.
- **Replacement:** fill all ENTRIES with distinct VPNs, then 3 further misses → victims are indices 0, 1, 2 in order.
- **Flush during WAIT:** flush asserted while in WAIT → PTW response 2 cycles later is not written, FSM returns to IDLE, same VPN misses again.
